// File: rtl/cpu_sequencer_if.sv
// ----------------------------------------------------------------------------
// cpu_sequencer_if
// Bundles the sequencer's control/handshake signals between the sequencer
// (master) and the RV32I datapath plus its memories (slave).
//   opcode/funct3          : instruction fields from the instruction register
//   imem_ready/dmem_ready  : memory ready handshakes
//   imem_req/dmem_req/...  : requests and write strobes driven by the sequencer
//   retire/instret         : retirement pulse and retired-instruction count
//   halted/err_code/state  : status and debug
// ----------------------------------------------------------------------------
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             mdr_we;
    logic             reg_we;
    logic             pc_we;
    logic             retire;
    logic             halted;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    modport master (
        input  opcode, funct3, imem_ready, dmem_ready,
        output imem_req, ir_we, dmem_req, dmem_we, mdr_we, reg_we, pc_we, retire,
        output halted, err_code, instret, state
    );

    modport slave (
        output opcode, funct3, imem_ready, dmem_ready,
        input  imem_req, ir_we, dmem_req, dmem_we, mdr_we, reg_we, pc_we, retire,
        input  halted, err_code, instret, state
    );
endinterface

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB scheduler for the RV32I datapath.
// Decides when the IR, PC, register file, MDR and data memory are written,
// counts retired instructions and halts on illegal encodings or memory
// timeouts.
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : cpu_sequencer_if master modport (handshakes, strobes, status)
// Parameters:
//   TIMEOUT  : max wait cycles on imem/dmem ready, 0 disables the timeout
//   CNT_W    : width of the retired-instruction counter
// ----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input logic             i_clk,
    input logic             i_rst_n,
    cpu_sequencer_if.master bus
);

    localparam int unsigned       WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IMEM_TO = 2'b10;
    localparam logic [1:0] ERR_DMEM_TO = 2'b11;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } state_e;

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_err;
    logic [CNT_W-1:0]  r_instret;

    logic w_is_load;
    logic w_is_store;
    logic w_is_branch;
    logic w_legal;
    logic w_wait_expired;

    logic w_imem_req;
    logic w_ir_we;
    logic w_dmem_req;
    logic w_dmem_we;
    logic w_mdr_we;
    logic w_reg_we;
    logic w_pc_we;
    logic w_retire;

    assign w_is_load   = (bus.opcode == OP_LOAD);
    assign w_is_store  = (bus.opcode == OP_STORE);
    assign w_is_branch = (bus.opcode == OP_BRANCH);

    // Expiry is judged on the registered count, so a ready seen in the same
    // cycle the count sits at TIMEOUT still completes the access.
    assign w_wait_expired = (TIMEOUT != 0) && (r_wait == WAIT_MAX);

    always_comb begin
        w_legal = 1'b0;
        case (bus.opcode)
            OP_IMM, OP_REG, OP_JAL, OP_LUI, OP_AUIPC: w_legal = 1'b1;
            OP_LOAD:   w_legal = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b110) &&
                                 (bus.funct3 != 3'b111);
            OP_STORE:  w_legal = (bus.funct3 <= 3'b010);
            OP_BRANCH: w_legal = (bus.funct3 != 3'b010) && (bus.funct3 != 3'b011);
            OP_JALR:   w_legal = (bus.funct3 == 3'b000);
            default:   w_legal = 1'b0;
        endcase
    end

    // Strobes are qualified by i_rst_n so they drop the instant reset asserts,
    // and imem_req stays low while the state register is held at FETCH.
    always_comb begin
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_mdr_we   = 1'b0;
        w_reg_we   = 1'b0;
        w_pc_we    = 1'b0;
        w_retire   = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                StFetch: begin
                    w_imem_req = 1'b1;
                    w_ir_we    = bus.imem_ready;
                end
                StExec: begin
                    if (w_is_branch) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                end
                StMem: begin
                    w_dmem_req = 1'b1;
                    w_dmem_we  = w_is_store;
                    if (bus.dmem_ready) begin
                        if (w_is_store) begin
                            w_pc_we  = 1'b1;
                            w_retire = 1'b1;
                        end else begin
                            w_mdr_we = 1'b1;
                        end
                    end
                end
                StWb: begin
                    w_reg_we = 1'b1;
                    w_pc_we  = 1'b1;
                    w_retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StFetch;
            r_wait    <= '0;
            r_err     <= ERR_NONE;
            r_instret <= '0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
            case (r_state)
                StFetch: begin
                    if (bus.imem_ready) begin
                        r_state <= StDecode;
                    end else if (w_wait_expired) begin
                        r_state <= StHalt;
                        r_err   <= ERR_IMEM_TO;
                    end else if (TIMEOUT != 0) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StDecode: begin
                    if (w_legal) begin
                        r_state <= StExec;
                    end else begin
                        r_state <= StHalt;
                        r_err   <= ERR_ILLEGAL;
                    end
                end
                StExec: begin
                    r_wait <= '0;
                    if (w_is_load || w_is_store) begin
                        r_state <= StMem;
                    end else if (w_is_branch) begin
                        r_state <= StFetch;
                    end else begin
                        r_state <= StWb;
                    end
                end
                StMem: begin
                    if (bus.dmem_ready) begin
                        r_wait  <= '0;
                        r_state <= w_is_store ? StFetch : StWb;
                    end else if (w_wait_expired) begin
                        r_state <= StHalt;
                        r_err   <= ERR_DMEM_TO;
                    end else if (TIMEOUT != 0) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StWb: begin
                    r_wait  <= '0;
                    r_state <= StFetch;
                end
                StHalt: ;
                // Unused encodings 5/6 are treated as a corrupted schedule.
                default: begin
                    r_state <= StHalt;
                    r_err   <= ERR_ILLEGAL;
                end
            endcase
        end
    end

    assign bus.imem_req = w_imem_req;
    assign bus.ir_we    = w_ir_we;
    assign bus.dmem_req = w_dmem_req;
    assign bus.dmem_we  = w_dmem_we;
    assign bus.mdr_we   = w_mdr_we;
    assign bus.reg_we   = w_reg_we;
    assign bus.pc_we    = w_pc_we;
    assign bus.retire   = w_retire;
    assign bus.halted   = (r_state == StHalt);
    assign bus.err_code = r_err;
    assign bus.instret  = r_instret;
    assign bus.state    = r_state;

endmodule
